// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: drives one shared external full adder LSB-first over WIDTH cycles.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement subtraction (a - b).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_sh_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic [WIDTH-1:0] b_load_s;
  logic             cin_load_s;
  logic [WIDTH-1:0] s_next_s;

  // Operand B and initial carry as loaded on start (subtract inverts B and forces carry-in)
  always_comb begin
    b_load_s   = b;
    cin_load_s = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load_s   = ~b;
      cin_load_s = 1'b1;
    end else begin
      b_load_s   = b;
      cin_load_s = cin;
    end
`endif
  end

  assign s_next_s = {fa_s, s_sh_r[WIDTH-1:1]};

  // The adder path is single-cycle, so its inputs come straight from the shift registers, gated to RUN
  assign fa_a = (state_r == RUN) & a_sh_r[0];
  assign fa_b = (state_r == RUN) & b_sh_r[0];
  assign fa_c = (state_r == RUN) & carry_r;

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

  // Sequencer FSM with datapath shift registers and registered status/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      s_sh_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b_load_s;
            s_sh_r  <= '0;
            carry_r <= cin_load_s;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          s_sh_r  <= s_next_s;
          a_sh_r  <= a_sh_r >> 1;
          b_sh_r  <= b_sh_r >> 1;
          carry_r <= fa_co;
          if (cnt_r == CNT_LAST) begin
            sum_r   <= s_next_s;
            cout_r  <= fa_co;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder on the fa_* ports.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
`endif
  logic       fa_a;
  logic       fa_b;
  logic       fa_c;
  logic       fa_s;
  logic       fa_co;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_c  (fa_c),
    .fa_s  (fa_s),
    .fa_co (fa_co),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after E0 (first RUN cycle)
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int         cyc;
  int         dcount;
  int         busy_bad;
  logic [7:0] fac_seq;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_fa", {fa_a, fa_b, fa_c}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x35 + 0x4A: busy for 8 cycles, done in the cycle after E8
    start_op(8'h35, 8'h4A, 1'b0);
    busy_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      if (i < 7) @(negedge clk);
    end
    check("t1_busy_window", busy_bad, 0);
    @(negedge clk);
    check("t1_done", done, 1'b1);
    check("t1_busy_off", busy, 1'b0);
    check("t1_sum", sum, 8'h7F);
    check("t1_cout", cout, 1'b0);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);
    check("t1_sum_hold", sum, 8'h7F);

    // 0xFF + 0x01, then 0xFF + 0xFF + 1 with hold of the first result
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(cyc);
    check("t2a_latency", cyc, 8);
    check("t2a_sum", sum, 8'h00);
    check("t2a_cout", cout, 1'b1);
    repeat (2) @(negedge clk);
    start_op(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    check("t2b_hold_sum", sum, 8'h00);
    check("t2b_hold_cout", cout, 1'b1);
    wait_done(cyc);
    check("t2b_done", done, 1'b1);
    check("t2b_sum", sum, 8'hFF);
    check("t2b_cout", cout, 1'b1);
    repeat (2) @(negedge clk);

    // start re-asserted with new operands during RUN is ignored
    start_op(8'h12, 8'h34, 1'b0);
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("t3_done_count", dcount, 1);
    check("t3_sum", sum, 8'h46);
    check("t3_cout", cout, 1'b0);

    // asynchronous reset after 4 RUN edges aborts with no done
    start_op(8'hA5, 8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_sum", sum, 8'h00);
    check("t4_rst_cout", cout, 1'b0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (i == 1) rst_n = 1'b1;
    end
    check("t4_no_done", dcount, 0);

    // 0x0F + 0x01: carry-in sequence presented to the adder, fa_* idle outside RUN
    check("t5_fa_idle", {fa_a, fa_b, fa_c}, 3'b000);
    start_op(8'h0F, 8'h01, 1'b0);
    fac_seq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fac_seq[i] = fa_c;
      if (i < 7) @(negedge clk);
    end
    check("t5_fa_c_seq", fac_seq, 8'h1E);
    @(negedge clk);
    check("t5_done", done, 1'b1);
    check("t5_fa_done", {fa_a, fa_b, fa_c}, 3'b000);
    check("t5_sum", sum, 8'h10);
    check("t5_cout", cout, 1'b0);
    @(negedge clk);
    check("t5_fa_idle_after", {fa_a, fa_b, fa_c}, 3'b000);

    // carry ripples through every bit
    start_op(8'hA5, 8'h5A, 1'b1);
    wait_done(cyc);
    check("t6_sum", sum, 8'h00);
    check("t6_cout", cout, 1'b1);
    repeat (2) @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    start_op(8'h10, 8'h03, 1'b0);
    sub = 1'b0;
    wait_done(cyc);
    check("sub1_sum", sum, 8'h0D);
    check("sub1_cout", cout, 1'b1);
    repeat (2) @(negedge clk);
    sub = 1'b1;
    start_op(8'h03, 8'h10, 1'b1);
    sub = 1'b0;
    wait_done(cyc);
    check("sub2_sum", sum, 8'hF3);
    check("sub2_cout", cout, 1'b0);
    repeat (2) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition sequencer. Time-shares one external 1-bit full adder instance across WIDTH bit positions to form a WIDTH-bit sum.
- Latches operands on start, drives the adder one bit per clock LSB-first, and registers the carry between cycles.
- Presents the result with a single-cycle done pulse.
- Sits between the operand/control source and the shared full adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  initial carry; sampled with start
- fa_a  output  1  to full adder input A
- fa_b  output  1  to full adder input B
- fa_c  output  1  to full adder carry input
- fa_s  input  1  full adder sum output
- fa_co  input  1  full adder carry output
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered final carry, held with sum

Behaviour:
- Reset is asynchronous and active-low, one clock: clk, rst_n. rst_n low forces:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, fa_a=0, fa_b=0, fa_c=0
  - internal shift registers, carry register and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a rising edge: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry. These are combinational from registers; the external adder path is single-cycle.
  - Each edge: capture fa_s into MSB of s_sh and shift s_sh right; shift a_sh and b_sh right; carry<=fa_co; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: load sum<=final s_sh value including the current fa_s, cout<=fa_co; go to DONE.
- DONE: done=1 for exactly this cycle; unconditional return to IDLE.
- fa_a, fa_b, fa_c are 0 in IDLE and DONE.
- Latency: start sampled at edge E0; bits processed at edges E1..E_WIDTH; sum/cout valid and done=1 in the cycle following E_WIDTH. Next start accepted at E_WIDTH+1 at the earliest.
- start in RUN or DONE is ignored; operand changes after E0 have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-RUN aborts immediately: no done, sum/cout forced to 0.
- cnt width is clog2(WIDTH); no wrap occurs because the count ends at WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1: b_sh<=~b and carry<=1 (cin ignored), giving sum=a-b mod 2^WIDTH; cout=1 means no borrow (a>=b unsigned).
  - sub=0: identical to add mode.
- Undefined: sub port absent; add only.

Test Plan:
All cases use WIDTH=8, with the bench wiring a behavioural 1-bit full adder to the fa_* ports.
- a=0x35, b=0x4A, cin=0, start pulse at E0 -> busy high for E1..E8 window; done=1 only in cycle after E8; sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; first result holds until second done.
- Start re-asserted with a=0x00, b=0x00 during RUN of a=0x12+b=0x34 -> ignored; sum=0x46, cout=0; exactly one done pulse.
- rst_n driven low after 4 RUN edges -> busy=0, sum=0, cout=0 asynchronously, no done. A following 0x0F+0x01 -> sum=0x10, cout=0.
- Monitor fa_c per RUN cycle for 0x0F+0x01, cin=0 -> sequence 0,1,1,1,1,0,0,0; fa_a, fa_b, fa_c are 0 in IDLE and DONE.
- SERIAL_ADD_SUB_EN: sub=1, a=0x10, b=0x03 -> sum=0x0D, cout=1. sub=1, a=0x03, b=0x10 -> sum=0xF3, cout=0.
